// File: rtl/store_commit_arb.sv
// store_commit_arb
//   Write buffer plus dcache port arbiter. Retired stores are compacted into a
//   circular FIFO (up to N_WAY per cycle). A single dcache port is shared between
//   store commit and load misses, with one request in flight at a time.
//
// Ports
//   clock, reset         : clock, asynchronous active-low reset
//   ret_*                : N_WAY retire lanes (valid, addr, data, size, pos)
//   wb_free              : free write-buffer entries (WB_DEPTH - count)
//   ld_req_* / ld_resp_* : load-miss request and data return
//   branch_haz           : squashes a latched load (stores are unaffected)
//   dc_req_* / dc_resp_* : dcache request and completion
//   st_ack_*             : committed store returned to the store queue
//
// Handshake: a dcache request transfers on a cycle where dc_req_valid and
// dc_req_ready are both 1; the fields stay stable while dc_req_valid is held.
// ld_req_ready is a one-cycle consume pulse for ld_req_valid. dc_resp_valid is
// only meaningful while a request is outstanding (WAIT) and is ignored
// otherwise. st_ack_valid and ld_resp_valid are single-cycle pulses.
module store_commit_arb #(
    parameter int N_WAY      = 2,
    parameter int XLEN       = 32,
    parameter int WB_DEPTH   = 8,
    parameter int HI_WM      = 6,
    parameter int STARVE_MAX = 4,
    parameter int PW         = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_WAY-1:0]            ret_valid,
    input  logic [N_WAY*XLEN-1:0]       ret_addr,
    input  logic [N_WAY*XLEN-1:0]       ret_data,
    input  logic [N_WAY*2-1:0]          ret_size,
    input  logic [N_WAY*PW-1:0]         ret_pos,
    output logic [$clog2(WB_DEPTH):0]   wb_free,
    input  logic                        ld_req_valid,
    input  logic [XLEN-1:0]             ld_req_addr,
    input  logic [1:0]                  ld_req_size,
    output logic                        ld_req_ready,
    output logic                        ld_resp_valid,
    output logic [XLEN-1:0]             ld_resp_data,
    input  logic                        branch_haz,
    output logic                        dc_req_valid,
    output logic                        dc_req_we,
    output logic [XLEN-1:0]             dc_req_addr,
    output logic [XLEN-1:0]             dc_req_data,
    output logic [1:0]                  dc_req_size,
    input  logic                        dc_req_ready,
    input  logic                        dc_resp_valid,
    input  logic [XLEN-1:0]             dc_resp_data,
    output logic                        st_ack_valid,
    output logic [XLEN-1:0]             st_ack_addr,
    output logic [PW-1:0]               st_ack_pos
);

    localparam int AW = $clog2(WB_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state, state_nx;

    logic [XLEN-1:0] mem_addr [WB_DEPTH];
    logic [XLEN-1:0] mem_data [WB_DEPTH];
    logic [1:0]      mem_size [WB_DEPTH];
    logic [PW-1:0]   mem_pos  [WB_DEPTH];

    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, free_cnt, n_enq;
    logic [SW-1:0]   starve;
    logic            squash;

    logic            lat_store;
    logic [XLEN-1:0] lat_addr, lat_data;
    logic [1:0]      lat_size;
    logic [PW-1:0]   lat_pos;

    logic [N_WAY-1:0] lane_acc;
    logic [AW-1:0]    lane_slot [N_WAY];
    logic             sel_store, sel_load, pop, resp_ok;

    assign free_cnt = CW'(WB_DEPTH) - count;
    assign wb_free  = free_cnt;

    // Compaction: the k-th accepted lane goes to wr_ptr+k. Capacity is judged
    // against the registered count, so lanes beyond it are dropped.
    always_comb begin
        n_enq    = '0;
        lane_acc = '0;
        for (int i = 0; i < N_WAY; i++) begin
            lane_slot[i] = wr_ptr + n_enq[AW-1:0];
            if (ret_valid[i] && (n_enq < free_cnt)) begin
                lane_acc[i] = 1'b1;
                n_enq       = n_enq + CW'(1);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        sel_store = 1'b0;
        sel_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && (!ld_req_valid || (count >= CW'(HI_WM)) ||
                                      (starve == SW'(STARVE_MAX)))) begin
                    sel_store = 1'b1;
                    state_nx  = S_ISSUE;
                end else if (ld_req_valid && !branch_haz) begin
                    sel_load = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: if (dc_req_ready) state_nx = S_WAIT;
            S_WAIT:  if (dc_resp_valid) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Head is released only when the store has actually completed.
    assign pop     = (state == S_WAIT) && dc_resp_valid && lat_store;
    // A hazard in the completion cycle itself also kills the load return.
    assign resp_ok = (state == S_WAIT) && dc_resp_valid && !lat_store && !squash && !branch_haz;

    // Gated by reset so the combinational pulse is also 0 while reset is held.
    assign ld_req_ready = sel_load & reset;
    assign dc_req_valid = (state == S_ISSUE);
    assign dc_req_we    = lat_store;
    assign dc_req_addr  = lat_addr;
    assign dc_req_data  = lat_data;
    assign dc_req_size  = lat_size;

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++) begin
            if (lane_acc[i]) begin
                mem_addr[lane_slot[i]] <= ret_addr[i*XLEN +: XLEN];
                mem_data[lane_slot[i]] <= ret_data[i*XLEN +: XLEN];
                mem_size[lane_slot[i]] <= ret_size[i*2 +: 2];
                mem_pos[lane_slot[i]]  <= ret_pos[i*PW +: PW];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            starve        <= '0;
            squash        <= 1'b0;
            lat_store     <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            lat_size      <= '0;
            lat_pos       <= '0;
            st_ack_valid  <= 1'b0;
            st_ack_addr   <= '0;
            st_ack_pos    <= '0;
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= '0;
        end else begin
            state  <= state_nx;
            wr_ptr <= wr_ptr + n_enq[AW-1:0];
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + n_enq - CW'(pop);

            if (sel_store)
                starve <= '0;
            else if (sel_load && (count != '0) && (starve != SW'(STARVE_MAX)))
                starve <= starve + SW'(1);

            if (sel_store) begin
                lat_store <= 1'b1;
                lat_addr  <= mem_addr[rd_ptr];
                lat_data  <= mem_data[rd_ptr];
                lat_size  <= mem_size[rd_ptr];
                lat_pos   <= mem_pos[rd_ptr];
            end else if (sel_load) begin
                lat_store <= 1'b0;
                lat_addr  <= ld_req_addr;
                lat_data  <= '0;
                lat_size  <= ld_req_size;
                lat_pos   <= '0;
            end

            if ((state == S_WAIT) && dc_resp_valid)
                squash <= 1'b0;
            else if ((state != S_IDLE) && !lat_store && branch_haz)
                squash <= 1'b1;

            st_ack_valid <= pop;
            if (pop) begin
                st_ack_addr <= lat_addr;
                st_ack_pos  <= lat_pos;
            end

            ld_resp_valid <= resp_ok;
            if (resp_ok) ld_resp_data <= dc_resp_data;
        end
    end

endmodule

// File: tb/tb_store_commit_arb.sv
module tb_store_commit_arb;
    localparam int N_WAY = 2, XLEN = 32, WB_DEPTH = 8, HI_WM = 6, STARVE_MAX = 4, PW = 4;

    logic                      clock, reset;
    logic [N_WAY-1:0]          ret_valid;
    logic [N_WAY*XLEN-1:0]     ret_addr, ret_data;
    logic [N_WAY*2-1:0]        ret_size;
    logic [N_WAY*PW-1:0]       ret_pos;
    logic [$clog2(WB_DEPTH):0] wb_free;
    logic                      ld_req_valid, ld_req_ready, ld_resp_valid, branch_haz;
    logic [XLEN-1:0]           ld_req_addr, ld_resp_data;
    logic [1:0]                ld_req_size, dc_req_size;
    logic                      dc_req_valid, dc_req_we, dc_req_ready, dc_resp_valid;
    logic [XLEN-1:0]           dc_req_addr, dc_req_data, dc_resp_data;
    logic                      st_ack_valid;
    logic [XLEN-1:0]           st_ack_addr;
    logic [PW-1:0]             st_ack_pos;

    store_commit_arb #(.N_WAY(N_WAY), .XLEN(XLEN), .WB_DEPTH(WB_DEPTH), .HI_WM(HI_WM),
                       .STARVE_MAX(STARVE_MAX), .PW(PW)) dut (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_data(ret_data),
        .ret_size(ret_size), .ret_pos(ret_pos), .wb_free(wb_free),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
        .ld_req_ready(ld_req_ready), .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .branch_haz(branch_haz),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_data(dc_req_data), .dc_req_size(dc_req_size), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .st_ack_valid(st_ack_valid), .st_ack_addr(st_ack_addr), .st_ack_pos(st_ack_pos)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [1:0]      size;
        logic [PW-1:0]   pos;
    } ent_t;

    ent_t wb_q[$];          // buffered stores, head at index 0
    bit   busy, issued, m_store, squashed;
    ent_t cur;              // the one outstanding dcache transaction
    int   starve;
    bit   ack_v, resp_v;
    logic [XLEN-1:0] ack_addr, resp_d;
    logic [PW-1:0]   ack_pos;

    logic            grant_log[$];   // dc_req_we of each accepted dcache request
    logic [PW-1:0]   ack_log[$];
    int              resp_cnt, rdy_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [PW-1:0] ack_at(input int i);
        return (i < ack_log.size()) ? ack_log[i] : 4'hx;
    endfunction

    function automatic logic grant_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 1'bx;
    endfunction

    function automatic void model_reset();
        wb_q.delete();
        busy = 0; issued = 0; m_store = 0; squashed = 0; starve = 0;
        ack_v = 0; resp_v = 0;
    endfunction

    // One cycle: called at a negedge with inputs already driven. Compares every
    // output against the model, advances the model across the posedge, and
    // returns at the next negedge.
    task automatic step();
        bit   sel_s, sel_l;
        int   cap, n;
        ent_t e;
        #1;
        if (!reset) begin
            check("rst_wb_free", wb_free, WB_DEPTH);
            check("rst_dc_req_valid", dc_req_valid, 0);
            check("rst_ld_req_ready", ld_req_ready, 0);
            check("rst_st_ack_valid", st_ack_valid, 0);
            check("rst_ld_resp_valid", ld_resp_valid, 0);
            model_reset();
        end else begin
            sel_s = !busy && (wb_q.size() > 0) &&
                    (!ld_req_valid || (wb_q.size() >= HI_WM) || (starve == STARVE_MAX));
            sel_l = !busy && !sel_s && ld_req_valid && !branch_haz;

            check("wb_free", wb_free, WB_DEPTH - wb_q.size());
            check("ld_req_ready", ld_req_ready, sel_l);
            check("dc_req_valid", dc_req_valid, busy && !issued);
            if (busy && !issued) begin
                check("dc_req_we", dc_req_we, m_store);
                check("dc_req_addr", dc_req_addr, cur.addr);
                check("dc_req_data", dc_req_data, cur.data);
                check("dc_req_size", dc_req_size, cur.size);
            end
            check("st_ack_valid", st_ack_valid, ack_v);
            if (ack_v) begin
                check("st_ack_addr", st_ack_addr, ack_addr);
                check("st_ack_pos", st_ack_pos, ack_pos);
            end
            check("ld_resp_valid", ld_resp_valid, resp_v);
            if (resp_v) check("ld_resp_data", ld_resp_data, resp_d);

            if (dc_req_valid && dc_req_ready) grant_log.push_back(dc_req_we);
            if (st_ack_valid) ack_log.push_back(st_ack_pos);
            if (ld_resp_valid) resp_cnt++;
            if (ld_req_ready) rdy_cnt++;

            cap   = WB_DEPTH - wb_q.size();
            ack_v = 0;
            resp_v = 0;
            if (busy) begin
                if (!m_store && branch_haz) squashed = 1;
                if (!issued) begin
                    if (dc_req_ready) issued = 1;
                end else if (dc_resp_valid) begin
                    busy = 0;
                    if (m_store) begin
                        ack_v = 1; ack_addr = cur.addr; ack_pos = cur.pos;
                        void'(wb_q.pop_front());
                    end else if (!squashed) begin
                        resp_v = 1; resp_d = dc_resp_data;
                    end
                    squashed = 0;
                end
            end
            if (sel_s) begin
                busy = 1; issued = 0; m_store = 1; cur = wb_q[0]; starve = 0;
            end else if (sel_l) begin
                busy = 1; issued = 0; m_store = 0;
                cur.addr = ld_req_addr; cur.data = '0; cur.size = ld_req_size; cur.pos = '0;
                if ((wb_q.size() > 0) && (starve < STARVE_MAX)) starve++;
            end
            n = 0;
            for (int i = 0; i < N_WAY; i++) begin
                if (ret_valid[i] && (n < cap)) begin
                    e.addr = ret_addr[i*XLEN +: XLEN];
                    e.data = ret_data[i*XLEN +: XLEN];
                    e.size = ret_size[i*2 +: 2];
                    e.pos  = ret_pos[i*PW +: PW];
                    wb_q.push_back(e);
                    n++;
                end
            end
        end
        @(negedge clock);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int i, input logic [PW-1:0] pos);
        ret_valid[i]              = 1'b1;
        ret_addr[i*XLEN +: XLEN]  = $urandom;
        ret_data[i*XLEN +: XLEN]  = $urandom;
        ret_size[i*2 +: 2]        = 2'($urandom_range(2));
        ret_pos[i*PW +: PW]       = pos;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ret_valid = '0; ld_req_valid = 1'b0; branch_haz = 1'b0;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        grant_log.delete(); ack_log.delete(); resp_cnt = 0; rdy_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        ret_valid = '0; ret_addr = '0; ret_data = '0; ret_size = '0; ret_pos = '0;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_size = '0; branch_haz = 1'b0;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
        model_reset();
        @(negedge clock);

        // Two-lane retire into an empty buffer, dcache always ready.
        do_reset();
        dc_req_ready = 1'b1; dc_resp_valid = 1'b1; dc_resp_data = $urandom;
        check("t1_free_empty", wb_free, 8);
        set_lane(0, 4'd1); set_lane(1, 4'd2);
        step();
        ret_valid = '0;
        check("t1_free_two", wb_free, 6);
        repeat (12) step();
        check("t1_ack_count", ack_log.size(), 2);
        check("t1_ack_first", ack_at(0), 1);
        check("t1_ack_second", ack_at(1), 2);
        check("t1_free_back", wb_free, 8);

        // Starvation: 3 stores buffered under continuous loads.
        do_reset();
        dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        ld_req_valid = 1'b1; ld_req_addr = $urandom; ld_req_size = 2'd2;
        set_lane(0, 4'd3); set_lane(1, 4'd4);
        step();
        ret_valid = '0;
        set_lane(0, 4'd5);
        step();
        ret_valid = '0;
        step();
        dc_req_ready = 1'b1;
        step();                       // the load picked while the buffer was empty
        grant_log.delete();
        repeat (36) step();
        for (int g = 0; g < 10; g++)
            check($sformatf("t2_grant%0d", g), grant_at(g), (g == 4 || g == 9) ? 1 : 0);
        ld_req_valid = 1'b0;

        // High watermark: 6 buffered stores beat a pending load.
        do_reset();
        dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        ld_req_valid = 1'b1; ld_req_addr = $urandom;
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 4'(2 * c)); set_lane(1, 4'(2 * c + 1));
            step();
            ret_valid = '0;
        end
        dc_req_ready = 1'b1;
        step();
        grant_log.delete(); rdy_cnt = 0;
        repeat (4) step();
        check("t3_first_grant_store", grant_at(0), 1);
        check("t3_ld_ready_quiet", rdy_cnt, 0);
        ld_req_valid = 1'b0;

        // Hazard while a load waits for its response.
        do_reset();
        dc_req_ready = 1'b1; dc_resp_valid = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = $urandom;
        step();
        ld_req_valid = 1'b0;
        step();
        branch_haz = 1'b1; set_lane(0, 4'd9);
        step();
        branch_haz = 1'b0; ret_valid = '0;
        resp_cnt = 0; ack_log.delete();
        dc_resp_valid = 1'b1; dc_resp_data = $urandom;
        step();
        repeat (6) step();
        check("t4_no_ld_resp", resp_cnt, 0);
        check("t4_store_acked", ack_log.size(), 1);
        check("t4_store_pos", ack_at(0), 9);

        // Write pointer wrap 7 -> 0, then retire concurrent with a pop.
        do_reset();
        dc_req_ready = 1'b1; dc_resp_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            set_lane(0, 4'(k));
            step();
            ret_valid = '0;
        end
        repeat (30) step();
        check("t5_drained", wb_free, 8);
        ack_log.delete();
        set_lane(0, 4'd7); set_lane(1, 4'd8);
        step();
        ret_valid = '0;
        check("t5_free_two", wb_free, 6);
        step();
        step();
        set_lane(0, 4'd9);
        step();                       // pop of the head in the same cycle
        ret_valid = '0;
        check("t5_free_simul", wb_free, 6);
        repeat (12) step();
        check("t5_ack_count", ack_log.size(), 3);
        check("t5_ack0", ack_at(0), 7);
        check("t5_ack1", ack_at(1), 8);
        check("t5_ack2", ack_at(2), 9);

        // Reset asserted while a store request is being presented.
        do_reset();
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        set_lane(0, 4'd5);
        step();
        ret_valid = '0;
        step();
        #2;
        check("t6_issue_before", dc_req_valid, 1);
        reset = 1'b0;
        #1;
        check("t6_valid_drop", dc_req_valid, 0);
        check("t6_free", wb_free, 8);
        model_reset();
        @(negedge clock);
        step();
        reset = 1'b1;
        ack_log.delete();
        dc_resp_valid = 1'b1;
        repeat (5) step();
        check("t6_no_stale_ack", ack_log.size(), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int lim;
            ret_valid = '0;
            lim = ($urandom_range(9) == 0) ? N_WAY : WB_DEPTH - wb_q.size();
            for (int i = 0; i < N_WAY; i++)
                if (($urandom_range(1) == 1) && (i < lim)) set_lane(i, 4'($urandom));
            ld_req_valid  = ($urandom_range(1) == 1);
            ld_req_addr   = $urandom;
            ld_req_size   = 2'($urandom_range(2));
            branch_haz    = ($urandom_range(9) == 0);
            dc_req_ready  = ($urandom_range(9) < 7);
            dc_resp_valid = ($urandom_range(1) == 1);
            dc_resp_data  = $urandom;
            reset         = ($urandom_range(499) != 0);
            step();
        end
        reset = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
